// File: rtl/bip_control_unit.sv
// BIP fetch/decode controller: two-cycle FETCH/EXEC sequencer driving program memory and datapath strobes.
// Optional free-running active-cycle counter enabled by defining BIP_CYCLE_COUNTER_EN.
module bip_control_unit #(
    parameter int PC_WIDTH      = 11,
    parameter int INSN_WIDTH    = 16,
    parameter int OPERAND_WIDTH = 11
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_enable,
    output logic [PC_WIDTH-1:0]      o_pm_addr,
    output logic                     o_pm_enb,
    input  logic [INSN_WIDTH-1:0]    i_pm_data,
    output logic [OPERAND_WIDTH-1:0] o_operand,
    output logic [1:0]               o_sel_a,
    output logic                     o_sel_b,
    output logic                     o_op,
    output logic                     o_wr_acc,
    output logic                     o_wr_ram,
    output logic                     o_rd_ram,
    output logic                     o_halt,
    output logic [PC_WIDTH-1:0]      o_pc
`ifdef BIP_CYCLE_COUNTER_EN
    ,
    output logic [31:0]              o_cycle_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    state_t                   state_reg;
    logic [PC_WIDTH-1:0]      pc_reg;
    logic [OPERAND_WIDTH-1:0] operand_reg;
    logic [4:0]               opcode;

    assign opcode = i_pm_data[INSN_WIDTH-1 -: 5];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= '0;
            operand_reg <= '0;
        end else if (i_enable) begin
            case (state_reg)
                ST_IDLE:  state_reg <= ST_FETCH;
                ST_FETCH: state_reg <= ST_EXEC;
                ST_EXEC: begin
                    operand_reg <= i_pm_data[OPERAND_WIDTH-1:0];
                    if (opcode == OP_HLT) begin
                        state_reg <= ST_HALT;
                    end else begin
                        pc_reg    <= pc_reg + PC_WIDTH'(1);
                        state_reg <= ST_FETCH;
                    end
                end
                default:  state_reg <= ST_HALT;
            endcase
        end
    end

    assign o_pm_addr = pc_reg;
    assign o_pc      = pc_reg;
    assign o_pm_enb  = (state_reg == ST_FETCH) && i_enable;
    assign o_halt    = (state_reg == ST_HALT);
    // Memory holds its output while disabled, so the live word stays valid through a stalled EXEC.
    assign o_operand = (state_reg == ST_EXEC) ? i_pm_data[OPERAND_WIDTH-1:0] : operand_reg;

    always_comb begin
        o_sel_a  = 2'b00;
        o_sel_b  = 1'b0;
        o_op     = 1'b0;
        o_wr_acc = 1'b0;
        o_wr_ram = 1'b0;
        o_rd_ram = 1'b0;
        if ((state_reg == ST_EXEC) && i_enable) begin
            case (opcode)
                OP_STO:  o_wr_ram = 1'b1;
                OP_LD: begin
                    o_rd_ram = 1'b1;
                    o_wr_acc = 1'b1;
                end
                OP_LDI: begin
                    o_sel_a  = 2'b01;
                    o_wr_acc = 1'b1;
                end
                OP_ADD: begin
                    o_rd_ram = 1'b1;
                    o_sel_a  = 2'b10;
                    o_wr_acc = 1'b1;
                end
                OP_ADDI: begin
                    o_sel_b  = 1'b1;
                    o_sel_a  = 2'b10;
                    o_wr_acc = 1'b1;
                end
                OP_SUB: begin
                    o_rd_ram = 1'b1;
                    o_sel_a  = 2'b10;
                    o_op     = 1'b1;
                    o_wr_acc = 1'b1;
                end
                OP_SUBI: begin
                    o_sel_b  = 1'b1;
                    o_sel_a  = 2'b10;
                    o_op     = 1'b1;
                    o_wr_acc = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef BIP_CYCLE_COUNTER_EN
    logic [31:0] cycle_count_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cycle_count_reg <= '0;
        end else if (i_enable && ((state_reg == ST_FETCH) || (state_reg == ST_EXEC))) begin
            cycle_count_reg <= cycle_count_reg + 32'd1;
        end
    end

    assign o_cycle_count = cycle_count_reg;
`endif

endmodule

// File: tb/tb_bip_control_unit.sv
// Scoreboard bench for bip_control_unit: stimulus pushes expected strobe records, a negedge monitor pops them.
module tb_bip_control_unit;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [10:0] pm_addr;
    logic        pm_enb;
    logic [15:0] pm_data;
    logic [10:0] operand;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        op;
    logic        wr_acc;
    logic        wr_ram;
    logic        rd_ram;
    logic        halt;
    logic [10:0] pc;
`ifdef BIP_CYCLE_COUNTER_EN
    logic [31:0] cycle_count;
`endif

    bip_control_unit dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_enable  (enable),
        .o_pm_addr (pm_addr),
        .o_pm_enb  (pm_enb),
        .i_pm_data (pm_data),
        .o_operand (operand),
        .o_sel_a   (sel_a),
        .o_sel_b   (sel_b),
        .o_op      (op),
        .o_wr_acc  (wr_acc),
        .o_wr_ram  (wr_ram),
        .o_rd_ram  (rd_ram),
        .o_halt    (halt),
        .o_pc      (pc)
`ifdef BIP_CYCLE_COUNTER_EN
        ,
        .o_cycle_count (cycle_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read program memory holding its output while disabled.
    logic [15:0] mem [0:2047];
    initial pm_data = 16'h0000;
    always @(posedge clk) if (pm_enb) pm_data <= mem[pm_addr];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int strobe_events = 0;
    int expected_events = 0;
    logic [17:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("check %-18s got %0h expected %0h ok", name, act, exp);
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Record layout: sel_a, sel_b, op, wr_acc, wr_ram, rd_ram, operand.
    function automatic logic [17:0] rec(input logic [1:0] a, input logic b, input logic o,
                                        input logic wa, input logic wr, input logic rr,
                                        input logic [10:0] opnd);
        return {a, b, o, wa, wr, rr, opnd};
    endfunction

    task automatic expect_strobe(input logic [17:0] r);
        exp_q.push_back(r);
        expected_events++;
    endtask

    always @(negedge clk) begin
        if (rst_n && (wr_acc || wr_ram || rd_ram)) begin
            strobe_events++;
            if (exp_q.size() == 0) begin
                check("spurious_strobe", {29'd0, wr_acc, wr_ram, rd_ram}, 32'd0);
            end else begin
                check("strobe_record", {14'd0, sel_a, sel_b, op, wr_acc, wr_ram, rd_ram, operand},
                      {14'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic do_reset();
        enable = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 2048; i++) mem[i] = 16'h4000;
    endtask

    task automatic wait_fetch(input string name);
        int n = 0;
        @(negedge clk);
        while (!pm_enb && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, pm_enb}, 32'd1);
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        enable = 1'b0;
        fill_nop();

        // Reset state
        do_reset();
        check("rst_pm_enb", {31'd0, pm_enb}, 32'd0);
        check("rst_pm_addr", {21'd0, pm_addr}, 32'd0);
        check("rst_halt", {31'd0, halt}, 32'd0);
        check("rst_outputs", {19'd0, sel_a, sel_b, op, operand}, 32'd0);

        // LDI 5; ADDI 3; STO 0x010; HLT
        mem[0] = 16'h1805; mem[1] = 16'h2803; mem[2] = 16'h0810; mem[3] = 16'h0000;
        expect_strobe(rec(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'd5));
        expect_strobe(rec(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'd3));
        expect_strobe(rec(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h010));
        enable = 1'b1;
        wait_fetch("prog1_fetch0");
        n = 0;
        while (!halt && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("prog1_halt_cycle", n, 32'd8);
        check("prog1_halt", {31'd0, halt}, 32'd1);
        check("prog1_pc_held", {21'd0, pc}, 32'd3);
        repeat (3) @(negedge clk);
        check("halt_pm_enb", {31'd0, pm_enb}, 32'd0);
        check("halt_pc_still", {21'd0, pm_addr}, 32'd3);
`ifdef BIP_CYCLE_COUNTER_EN
        check("halt_cycle_count", cycle_count, 32'd8);
`endif

        // LD 0x004; SUB 0x004; HLT
        do_reset();
        mem[0] = 16'h1004; mem[1] = 16'h3004; mem[2] = 16'h0000;
        expect_strobe(rec(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 11'd4));
        expect_strobe(rec(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 11'd4));
        enable = 1'b1;
        wait_fetch("prog2_fetch0");
        n = 0;
        while (!halt && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("prog2_halt", {31'd0, halt}, 32'd1);
        check("prog2_pc", {21'd0, pc}, 32'd2);

        // Enable dropped for 3 cycles during EXEC of LDI 7
        do_reset();
        mem[0] = 16'h1807; mem[1] = 16'h0000;
        expect_strobe(rec(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'd7));
        enable = 1'b1;
        wait_fetch("stall_fetch0");
        @(posedge clk);
        #1 enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_strobes", {28'd0, wr_acc, wr_ram, rd_ram, pm_enb}, 32'd0);
            check("stall_pc", {21'd0, pc}, 32'd0);
            check("stall_operand", {21'd0, operand}, 32'd7);
        end
        enable = 1'b1;
        repeat (6) @(negedge clk);
        check("stall_halt", {31'd0, halt}, 32'd1);
        check("stall_pc_end", {21'd0, pc}, 32'd1);

        // Reset mid-EXEC of ADD 0x005
        do_reset();
        mem[0] = 16'h2005;
        enable = 1'b1;
        wait_fetch("rstx_fetch0");
        @(posedge clk);
        #1;
        check("rstx_active", {30'd0, wr_acc, rd_ram}, 32'd3);
        rst_n = 1'b0;
        #1;
        check("rstx_strobes", {28'd0, wr_acc, wr_ram, rd_ram, pm_enb}, 32'd0);
        check("rstx_sel_op", {28'd0, sel_a, sel_b, op}, 32'd0);
        check("rstx_pm_addr", {21'd0, pm_addr}, 32'd0);
        check("rstx_operand", {21'd0, operand}, 32'd0);
        enable = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 enable = 1'b1;
        @(negedge clk);
        check("rstx_idle_enb", {31'd0, pm_enb}, 32'd0);
        @(negedge clk);
        check("rstx_first_fetch", {20'd0, pm_enb, pm_addr}, {20'd0, 1'b1, 11'd0});

        // Opcode 11111 as NOP, then PC wrap across all NOPs
        do_reset();
        fill_nop();
        mem[0] = 16'hF800;
        enable = 1'b1;
        wait_fetch("wrap_fetch0");
        repeat (2) @(negedge clk);
        check("nop11111_pc", {20'd0, pm_enb, pm_addr}, {20'd0, 1'b1, 11'd1});
`ifdef BIP_CYCLE_COUNTER_EN
        check("nop_cycle_count", cycle_count, 32'd2);
`endif
        repeat (2 * 2046) @(negedge clk);
        check("wrap_pc_last", {20'd0, pm_enb, pm_addr}, {20'd0, 1'b1, 11'd2047});
        repeat (2) @(negedge clk);
        check("wrap_pc_zero", {19'd0, halt, pm_enb, pm_addr}, {19'd0, 1'b0, 1'b1, 11'd0});
        repeat (2) @(negedge clk);
        check("wrap_pc_one", {21'd0, pc}, 32'd1);

        enable = 1'b0;
        @(negedge clk);
        check("sb_queue_empty", exp_q.size(), 32'd0);
        check("sb_event_count", strobe_events, expected_events);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bip_control_unit.md
Name: bip_control_unit

Overview:
- Fetch/decode controller for the BIP processor; sits directly upstream of the program memory.
- Drives the program memory address and read enable from an internal PC, and consumes the 16-bit instruction word one cycle later.
- Decodes the 5-bit opcode into datapath strobes for the accumulator, ALU and data memory.
- Fixed rate: 2 cycles per instruction (FETCH, EXEC), with halt and global enable.

Parameters:
- PC_WIDTH, 11, program counter / program memory address width (2048 words).
- INSN_WIDTH, 16, instruction width; opcode = [INSN_WIDTH-1:INSN_WIDTH-5], operand = [INSN_WIDTH-6:0].
- OPERAND_WIDTH, 11, operand field width; must equal INSN_WIDTH-5.

Ports:
- i_clk  in  1  clock, all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_enable  in  1  run enable; low freezes the FSM and PC.
- o_pm_addr  out  PC_WIDTH  program memory read address (= PC).
- o_pm_enb  out  1  program memory read enable.
- i_pm_data  in  INSN_WIDTH  instruction word; valid one cycle after o_pm_enb.
- o_operand  out  OPERAND_WIDTH  operand field of the current instruction, raw and unextended.
- o_sel_a  out  2  accumulator source: 00 data memory, 01 operand, 10 ALU result.
- o_sel_b  out  1  ALU B source: 0 data memory, 1 operand.
- o_op  out  1  ALU operation: 0 add, 1 subtract.
- o_wr_acc  out  1  accumulator write strobe.
- o_wr_ram  out  1  data memory write strobe.
- o_rd_ram  out  1  data memory read strobe.
- o_halt  out  1  high once HLT has executed.
- o_pc  out  PC_WIDTH  current PC, for debug.

Behaviour:
- States: IDLE, FETCH, EXEC, HALT.
- Reset (async, any state, mid-instruction included):
  - state = IDLE, PC = 0.
  - o_pm_enb, o_halt and all strobes = 0; o_sel_a = 00; o_sel_b = 0; o_op = 0; o_operand = 0; o_pm_addr = 0.
- IDLE: all outputs inactive; moves to FETCH on the first cycle with i_enable = 1.
- FETCH: o_pm_enb = i_enable, o_pm_addr = PC; moves to EXEC when i_enable = 1.
- EXEC:
  - Decode i_pm_data and assert the strobes for exactly one cycle, only while i_enable = 1.
  - PC <= PC+1 and next state = FETCH, except on HLT.
  - HLT: PC unchanged, next state = HALT.
- i_enable = 0 in any state: state and PC hold, all strobes and o_pm_enb = 0. The program memory holds its output while its enable is low, so EXEC resumes correctly when i_enable returns to 1.
- HALT: o_halt = 1, all strobes 0, o_pm_enb = 0; exit only via reset.
- Decode table (strobes not listed = 0; sel/op unlisted = 0):
  - 00000 HLT: none.
  - 00001 STO: wr_ram.
  - 00010 LD: rd_ram, sel_a = 00, wr_acc.
  - 00011 LDI: sel_a = 01, wr_acc.
  - 00100 ADD: rd_ram, sel_b = 0, sel_a = 10, op = 0, wr_acc.
  - 00101 ADDI: sel_b = 1, sel_a = 10, op = 0, wr_acc.
  - 00110 SUB: rd_ram, sel_b = 0, sel_a = 10, op = 1, wr_acc.
  - 00111 SUBI: sel_b = 1, sel_a = 10, op = 1, wr_acc.
  - 01000-11111: NOP; no strobes, PC increments.
- o_operand = i_pm_data[OPERAND_WIDTH-1:0] during EXEC, otherwise the last value held.
- PC arithmetic is modulo 2^PC_WIDTH: increment from 2^PC_WIDTH-1 wraps to 0, no flag.
- Strobes are combinational from the registered state plus i_pm_data and i_enable. o_pc and o_pm_addr are registered.

Optional Feature:
- Macro: BIP_CYCLE_COUNTER_EN.
- With the macro defined:
  - Adds output o_cycle_count (32 bits), which counts every cycle with i_enable = 1 and state ≠ IDLE/HALT.
  - The count freezes in HALT, resets to 0 on i_rst_n, and wraps at 2^32.
- Without the macro: no port and no counter logic.

Test Plan:
- Reset mid-EXEC: assert i_rst_n = 0 during EXEC of ADD → all strobes 0 immediately (async); after release, first o_pm_addr = 0 with o_pm_enb = 1 one cycle after i_enable = 1.
- Program LDI 5; ADDI 3; STO 0x010; HLT (0x1805, 0x2803, 0x0810, 0x0000) → strobe sequence:
  - LDI: wr_acc with sel_a = 01, operand 5.
  - ADDI: wr_acc with sel_a = 10, sel_b = 1, op = 0, operand 3.
  - STO: wr_ram with operand 0x010.
  - Then o_halt = 1 at cycle 8, with PC = 3 held.
- LD 0x004 then SUB 0x004 → LD: rd_ram = 1, sel_a = 00; SUB: rd_ram = 1, sel_b = 0, op = 1, wr_acc = 1.
- i_enable dropped for 3 cycles during EXEC → no strobes and o_pm_enb = 0 for those cycles; PC unchanged; same instruction executes once after re-enable.
- PC wrap: memory filled with NOP 0x4000 → after 2048 instructions, o_pm_addr returns to 0 with no glitch or halt.
- Opcode 0xF800 (11111) → no strobes, PC increments; with BIP_CYCLE_COUNTER_EN, o_cycle_count = 2 after one enabled instruction.
